// File: rtl/fsqrt_pkg.sv
// fsqrt_pkg: shared constants, state encoding and operand class codes for the FP32 sqrt issue stage
//  FP_QNAN / FP_PINF : canonical bypass results
//  state_t           : IDLE / RUN / DONE issue-controller states
//  cls_t             : FP32 operand classes, produced by fp32_classify
package fsqrt_pkg;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CLS_SNAN = 3'd0,
        CLS_QNAN = 3'd1,
        CLS_ZERO = 3'd2,
        CLS_NEG  = 3'd3,
        CLS_PINF = 3'd4,
        CLS_SUB  = 3'd5,
        CLS_NORM = 3'd6
    } cls_t;

endpackage

// File: rtl/fsqrt_issue_ctrl_if.sv
// fsqrt_issue_ctrl_if: operand, sqrt-core and result handshake bundle of the sqrt issue stage
//  in_valid/in_ready/A                     : operand handshake
//  core_a/core_en/core_result              : sqrt core connection
//  out_valid/out_ready/OUT_FSQRT/flag_*    : result handshake
//  slave  : the issue controller side
//  master : the surrounding ALU / core / bench side
interface fsqrt_issue_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] core_a;
    logic        core_en;
    logic [31:0] core_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] OUT_FSQRT;
    logic        flag_invalid;
    logic        flag_special;

    modport slave (
        input  in_valid, A, core_result, out_ready,
        output in_ready, core_a, core_en, out_valid, OUT_FSQRT, flag_invalid, flag_special
    );

    modport master (
        output in_valid, A, core_result, out_ready,
        input  in_ready, core_a, core_en, out_valid, OUT_FSQRT, flag_invalid, flag_special
    );

endinterface

// File: rtl/fp32_classify.sv
// fp32_classify: combinational FP32 operand classifier for the FP ALU issue stages
//  a   in  32  FP32 operand
//  cls out  3  class code, priority sNaN > qNaN > +-0 > negative > +inf > subnormal > normal
module fp32_classify
    import fsqrt_pkg::*;
(
    input  logic [31:0] a,
    output cls_t        cls
);

    logic exp_ff;
    logic exp_00;
    logic man_nz;

    assign exp_ff = &a[30:23];
    assign exp_00 = ~|a[30:23];
    assign man_nz = |a[22:0];

    always_comb begin
        cls = (exp_ff && man_nz && !a[22]) ? CLS_SNAN :
              (exp_ff && man_nz)           ? CLS_QNAN :
              (a[30:0] == 31'd0)           ? CLS_ZERO :
              a[31]                        ? CLS_NEG  :
              exp_ff                       ? CLS_PINF :
              exp_00                       ? CLS_SUB  : CLS_NORM;
    end

endmodule

// File: rtl/fsqrt_issue_ctrl.sv
// fsqrt_issue_ctrl: issue/retire controller in front of the pipelined FP32 square-root core
//  CLK  in  clock, rising edge
//  RST  in  asynchronous reset, active-low
//  EN   in  block enable; low clears everything at the next edge
//  bus  slave side of fsqrt_issue_ctrl_if (operand, core and result handshakes)
//  CORE_LAT : cycles the core needs with core_a held and core_en high
//  FSQRT_FTZ_EN : when defined, subnormal operands are flushed to signed zero
module fsqrt_issue_ctrl
    import fsqrt_pkg::*;
#(
    parameter int CORE_LAT = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    fsqrt_issue_ctrl_if.slave   bus
);

    localparam int CW = $clog2(CORE_LAT + 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] count;
    logic [31:0]   op_q;
    logic [31:0]   res_q;
    logic          inv_q;
    logic          spc_q;
    cls_t          cls;
    logic          accept;
    logic          ftz;
    logic          bypass;
    logic [31:0]   byp_res;
    logic          byp_inv;

    fp32_classify u_classify (
        .a   (bus.A),
        .cls (cls)
    );

    assign accept = bus.in_valid && bus.in_ready;

`ifdef FSQRT_FTZ_EN
    // Any exponent-zero operand that is not a true zero (either sign) is flushed.
    assign ftz = (bus.A[30:23] == 8'd0) && (cls == CLS_SUB || cls == CLS_NEG);
`else
    assign ftz = 1'b0;
`endif

    assign bypass  = ftz || (cls != CLS_SUB && cls != CLS_NORM);
    assign byp_res = ftz                ? {bus.A[31], 31'd0} :
                     (cls == CLS_ZERO)  ? bus.A :
                     (cls == CLS_PINF)  ? FP_PINF : FP_QNAN;
    assign byp_inv = !ftz && (cls == CLS_SNAN || cls == CLS_NEG);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= EN ? state_nx : IDLE;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.in_valid ? (bypass ? DONE : RUN) : IDLE;
            RUN:     state_nx = (count == '0) ? DONE : RUN;
            DONE:    state_nx = bus.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // in_ready also drops while RST is asserted so every output reads 0 in reset.
    always_comb begin
        bus.in_ready     = (state == IDLE) && EN && RST;
        bus.core_en      = (state == RUN);
        bus.out_valid    = (state == DONE);
        bus.core_a       = op_q;
        bus.OUT_FSQRT    = res_q;
        bus.flag_invalid = inv_q;
        bus.flag_special = spc_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
            op_q  <= '0;
            res_q <= '0;
            inv_q <= 1'b0;
            spc_q <= 1'b0;
        end else if (!EN) begin
            count <= '0;
            op_q  <= '0;
            res_q <= '0;
            inv_q <= 1'b0;
            spc_q <= 1'b0;
        end else if (accept) begin
            op_q  <= bus.A;
            count <= CW'(CORE_LAT - 1);
            if (bypass) begin
                res_q <= byp_res;
                inv_q <= byp_inv;
                spc_q <= 1'b1;
            end
        end else if (state == RUN) begin
            count <= (count == '0) ? count : count - 1'b1;
            if (count == '0) begin
                res_q <= bus.core_result;
                inv_q <= 1'b0;
                spc_q <= 1'b0;
            end
        end
    end

endmodule
